// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: miss handler sitting in front of a 2-way cache.
// Accepts one lookup at a time, refills the block from DRAM beat by beat on a
// miss, then replays the lookup so the data returns as a hit.
// Optional feature macro: CACHE_REFILL_PERF_EN (adds hit_count / miss_count).

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module cache_refill_ctrl #(
    parameter int unsigned BLOCK_SIZE_BITS = 64,
    parameter int unsigned BEAT_BITS       = 64,
    parameter int unsigned ADDR_WIDTH      = `ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_aH,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    output logic                       resp_valid,
    output logic [BLOCK_SIZE_BITS-1:0] resp_data,
    output logic                       busy,
    output logic [ADDR_WIDTH-1:0]      cache_addr,
    output logic                       cache_csb0,
    output logic                       cache_we_aL,
    output logic [BEAT_BITS-1:0]       cache_write_data,
    input  logic                       cache_hit,
    input  logic [BLOCK_SIZE_BITS-1:0] cache_rdata,
    output logic                       dram_req_valid,
    input  logic                       dram_req_ready,
    output logic [ADDR_WIDTH-1:0]      dram_req_addr,
    input  logic                       dram_resp_valid,
    input  logic [BEAT_BITS-1:0]       dram_resp_data
`ifdef CACHE_REFILL_PERF_EN
    ,
    output logic [31:0]                hit_count,
    output logic [31:0]                miss_count
`endif
);

    localparam int unsigned NUM_BEATS  = BLOCK_SIZE_BITS / BEAT_BITS;
    localparam int unsigned BlockBytes = BLOCK_SIZE_BITS / 8;
    localparam int unsigned BeatBytes  = BEAT_BITS / 8;
    localparam int unsigned BeatCntW   = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [ADDR_WIDTH-1:0] OffMask = ADDR_WIDTH'(BlockBytes - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StDramReq,
        StDramWait,
        StReplay
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
    logic [BeatCntW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [ADDR_WIDTH-1:0] block_base;
    logic [ADDR_WIDTH-1:0] beat_off;
    logic                  last_beat;

    assign block_base = miss_addr_q & ~OffMask;
    assign beat_off   = ADDR_WIDTH'(beat_cnt_q) * ADDR_WIDTH'(BeatBytes);
    assign last_beat  = (beat_cnt_q == BeatCntW'(NUM_BEATS - 1));

    // State and refill bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_aH) begin
            state_q     <= StIdle;
            miss_addr_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    // Next-state and output decode; reset forces the idle output values.
    always_comb begin
        state_d          = state_q;
        miss_addr_d      = miss_addr_q;
        beat_cnt_d       = beat_cnt_q;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        busy             = 1'b0;
        cache_addr       = '0;
        cache_csb0       = 1'b1;
        cache_we_aL      = 1'b1;
        cache_write_data = '0;
        dram_req_valid   = 1'b0;
        dram_req_addr    = block_base;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cache_csb0  = 1'b0;
                    cache_addr  = req_addr;
                    miss_addr_d = req_addr;
                    state_d     = StLookup;
                end
            end
            StLookup: begin
                if (cache_hit) begin
                    resp_valid = 1'b1;
                    state_d    = StIdle;
                end else begin
                    state_d = StDramReq;
                end
            end
            StDramReq: begin
                busy           = 1'b1;
                dram_req_valid = 1'b1;
                if (dram_req_ready) begin
                    beat_cnt_d = '0;
                    state_d    = StDramWait;
                end
            end
            StDramWait: begin
                busy = 1'b1;
                if (dram_resp_valid) begin
                    cache_csb0       = 1'b0;
                    cache_we_aL      = 1'b0;
                    cache_write_data = dram_resp_data;
                    cache_addr       = block_base | beat_off;
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        state_d    = StReplay;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BeatCntW'(1);
                    end
                end
            end
            StReplay: begin
                busy       = 1'b1;
                cache_csb0 = 1'b0;
                cache_addr = miss_addr_q;
                state_d    = StLookup;
            end
            default: state_d = StIdle;
        endcase

        // Abort immediately: no cache access or DRAM request during reset.
        if (rst_aH) begin
            req_ready        = 1'b1;
            resp_valid       = 1'b0;
            busy             = 1'b0;
            cache_addr       = '0;
            cache_csb0       = 1'b1;
            cache_we_aL      = 1'b1;
            cache_write_data = '0;
            dram_req_valid   = 1'b0;
        end
    end

    assign resp_data = resp_valid ? cache_rdata : '0;

`ifdef CACHE_REFILL_PERF_EN
    logic        replay_q;
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    // Count first-lookup outcomes only; a lookup right after a replay is skipped.
    always_ff @(posedge clk) begin
        if (rst_aH) begin
            replay_q     <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            replay_q <= (state_q == StReplay);
            if (state_q == StLookup && !replay_q) begin
                if (cache_hit) begin
                    if (hit_count_q != 32'hFFFF_FFFF) hit_count_q <= hit_count_q + 32'd1;
                end else begin
                    if (miss_count_q != 32'hFFFF_FFFF) miss_count_q <= miss_count_q + 32'd1;
                end
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
